// File: rtl/rs_br_inorder.sv
// Branch reservation station: an in-order circular buffer of branch/jump uops.
// Operands are captured from two CDB ports; the head issues once both operands are ready.
module rs_br_inorder #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_full,
  input  logic              i_flush,
  input  logic              i_disp_vld,
  input  logic              i_disp_is_jal,
  input  logic              i_disp_is_jalr,
  input  logic [OP_W-1:0]   i_disp_alu_op_sel,
  input  logic [PC_W-1:0]   i_disp_pc,
  input  logic [DATA_W-1:0] i_disp_imm,
  input  logic [PC_W-1:0]   i_disp_pred_jmpaddr,
  input  logic [TAG_W-1:0]  i_disp_rob_tag,
  input  logic              i_disp_rs1_rdy,
  input  logic              i_disp_rs2_rdy,
  input  logic [DATA_W-1:0] i_disp_rs1,
  input  logic [DATA_W-1:0] i_disp_rs2,
  input  logic              i_cdb0_vld,
  input  logic              i_cdb1_vld,
  input  logic [TAG_W-1:0]  i_cdb0_tag,
  input  logic [TAG_W-1:0]  i_cdb1_tag,
  input  logic [DATA_W-1:0] i_cdb0_data,
  input  logic [DATA_W-1:0] i_cdb1_data,
  input  logic              i_ex_accessable,
  output logic              o_is_vld,
  output logic              o_is_jal,
  output logic              o_is_jalr,
  output logic [OP_W-1:0]   o_alu_op_sel,
  output logic [DATA_W-1:0] o_rs1,
  output logic [DATA_W-1:0] o_rs2,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_imm,
  output logic [PC_W-1:0]   o_pred_jmpaddr,
  output logic [TAG_W-1:0]  o_rob_tag
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // cdb0 is checked first so it wins when both ports carry the same tag.
  function automatic snoop_t snoop(
    input logic [TAG_W-1:0]  tag,
    input logic              vld0,
    input logic [TAG_W-1:0]  tag0,
    input logic [DATA_W-1:0] data0,
    input logic              vld1,
    input logic [TAG_W-1:0]  tag1,
    input logic [DATA_W-1:0] data1
  );
    snoop_t s;
    s = '0;
    if (vld0 && tag0 == tag) begin
      s.hit  = 1'b1;
      s.data = data0;
    end else if (vld1 && tag1 == tag) begin
      s.hit  = 1'b1;
      s.data = data1;
    end
    return s;
  endfunction

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic [DEPTH-1:0] ent_vld, ent_rs1_rdy, ent_rs2_rdy, ent_jal, ent_jalr;
  logic [DATA_W-1:0] ent_rs1 [DEPTH];
  logic [DATA_W-1:0] ent_rs2 [DEPTH];
  logic [DATA_W-1:0] ent_imm [DEPTH];
  logic [PC_W-1:0]   ent_pc  [DEPTH];
  logic [PC_W-1:0]   ent_pred[DEPTH];
  logic [OP_W-1:0]   ent_op  [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];

  snoop_t wake1 [DEPTH];
  snoop_t wake2 [DEPTH];
  snoop_t disp1, disp2;
  logic   disp_acc, issue;

  assign o_full   = !rst && (count == (PTR_W+1)'(DEPTH));
  assign disp_acc = i_disp_vld && !o_full && !i_flush;
  // Only registered ready flags gate issue; a same-cycle broadcast is seen next cycle.
  assign issue    = !rst && !i_flush && i_ex_accessable && (count != '0)
                    && ent_rs1_rdy[head] && ent_rs2_rdy[head];
  assign o_is_vld = issue;

  // NOTE: every variable driven in always_comb is assigned on all paths, so no latch is inferred.
  always_comb begin
    disp1 = snoop(i_disp_rs1[TAG_W-1:0], i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                  i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
    disp2 = snoop(i_disp_rs2[TAG_W-1:0], i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                  i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = snoop(ent_rs1[i][TAG_W-1:0], i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                       i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
      wake2[i] = snoop(ent_rs2[i][TAG_W-1:0], i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                       i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      head           <= '0;
      tail           <= '0;
      ent_vld        <= '0;
      ent_rs1_rdy    <= '0;
      ent_rs2_rdy    <= '0;
      o_is_jal       <= 1'b0;
      o_is_jalr      <= 1'b0;
      o_alu_op_sel   <= '0;
      o_rs1          <= '0;
      o_rs2          <= '0;
      o_pc           <= '0;
      o_imm          <= '0;
      o_pred_jmpaddr <= '0;
      o_rob_tag      <= '0;
    end else if (i_flush) begin
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      ent_vld     <= '0;
      ent_rs1_rdy <= '0;
      ent_rs2_rdy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && !ent_rs1_rdy[i] && wake1[i].hit) ent_rs1_rdy[i] <= 1'b1;
        if (ent_vld[i] && !ent_rs2_rdy[i] && wake2[i].hit) ent_rs2_rdy[i] <= 1'b1;
      end
      if (disp_acc) begin
        ent_vld[tail]     <= 1'b1;
        ent_rs1_rdy[tail] <= i_disp_rs1_rdy || disp1.hit;
        ent_rs2_rdy[tail] <= i_disp_rs2_rdy || disp2.hit;
        tail              <= tail + PTR_W'(1);
      end
      if (issue) begin
        ent_vld[head]     <= 1'b0;
        ent_rs1_rdy[head] <= 1'b0;
        ent_rs2_rdy[head] <= 1'b0;
        head              <= head + PTR_W'(1);
        o_is_jal          <= ent_jal[head];
        o_is_jalr         <= ent_jalr[head];
        o_alu_op_sel      <= ent_op[head];
        o_rs1             <= ent_rs1[head];
        o_rs2             <= ent_rs2[head];
        o_pc              <= ent_pc[head];
        o_imm             <= ent_imm[head];
        o_pred_jmpaddr    <= ent_pred[head];
        o_rob_tag         <= ent_tag[head];
      end
      count <= count + (PTR_W+1)'(disp_acc) - (PTR_W+1)'(issue);
    end
  end

  // NOTE: entry payload storage has no reset; the valid/ready flags alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !ent_rs1_rdy[i] && wake1[i].hit) ent_rs1[i] <= wake1[i].data;
      if (ent_vld[i] && !ent_rs2_rdy[i] && wake2[i].hit) ent_rs2[i] <= wake2[i].data;
    end
    if (disp_acc) begin
      ent_rs1[tail]  <= (!i_disp_rs1_rdy && disp1.hit) ? disp1.data : i_disp_rs1;
      ent_rs2[tail]  <= (!i_disp_rs2_rdy && disp2.hit) ? disp2.data : i_disp_rs2;
      ent_jal[tail]  <= i_disp_is_jal;
      ent_jalr[tail] <= i_disp_is_jalr;
      ent_op[tail]   <= i_disp_alu_op_sel;
      ent_pc[tail]   <= i_disp_pc;
      ent_imm[tail]  <= i_disp_imm;
      ent_pred[tail] <= i_disp_pred_jmpaddr;
      ent_tag[tail]  <= i_disp_rob_tag;
    end
  end

endmodule

// File: tb/tb_rs_br_inorder.sv
// Directed bench for rs_br_inorder: dispatch, wakeup, bypass, in-order issue, full, flush and reset.
module tb_rs_br_inorder;

  localparam int DEPTH = 4, DATA_W = 32, PC_W = 32, OP_W = 4, TAG_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              o_full, i_flush, i_disp_vld, i_disp_is_jal, i_disp_is_jalr;
  logic [OP_W-1:0]   i_disp_alu_op_sel;
  logic [PC_W-1:0]   i_disp_pc, i_disp_pred_jmpaddr;
  logic [DATA_W-1:0] i_disp_imm, i_disp_rs1, i_disp_rs2;
  logic [TAG_W-1:0]  i_disp_rob_tag;
  logic              i_disp_rs1_rdy, i_disp_rs2_rdy;
  logic              i_cdb0_vld, i_cdb1_vld;
  logic [TAG_W-1:0]  i_cdb0_tag, i_cdb1_tag;
  logic [DATA_W-1:0] i_cdb0_data, i_cdb1_data;
  logic              i_ex_accessable;
  logic              o_is_vld, o_is_jal, o_is_jalr;
  logic [OP_W-1:0]   o_alu_op_sel;
  logic [DATA_W-1:0] o_rs1, o_rs2, o_imm;
  logic [PC_W-1:0]   o_pc, o_pred_jmpaddr;
  logic [TAG_W-1:0]  o_rob_tag;

  int checks = 0;
  int errors = 0;

  rs_br_inorder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .o_full(o_full), .i_flush(i_flush),
    .i_disp_vld(i_disp_vld), .i_disp_is_jal(i_disp_is_jal), .i_disp_is_jalr(i_disp_is_jalr),
    .i_disp_alu_op_sel(i_disp_alu_op_sel), .i_disp_pc(i_disp_pc), .i_disp_imm(i_disp_imm),
    .i_disp_pred_jmpaddr(i_disp_pred_jmpaddr), .i_disp_rob_tag(i_disp_rob_tag),
    .i_disp_rs1_rdy(i_disp_rs1_rdy), .i_disp_rs2_rdy(i_disp_rs2_rdy),
    .i_disp_rs1(i_disp_rs1), .i_disp_rs2(i_disp_rs2),
    .i_cdb0_vld(i_cdb0_vld), .i_cdb1_vld(i_cdb1_vld), .i_cdb0_tag(i_cdb0_tag), .i_cdb1_tag(i_cdb1_tag),
    .i_cdb0_data(i_cdb0_data), .i_cdb1_data(i_cdb1_data), .i_ex_accessable(i_ex_accessable),
    .o_is_vld(o_is_vld), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr), .o_alu_op_sel(o_alu_op_sel),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_pc(o_pc), .o_imm(o_imm),
    .o_pred_jmpaddr(o_pred_jmpaddr), .o_rob_tag(o_rob_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after a further settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_disp_vld = 0; i_disp_is_jal = 0; i_disp_is_jalr = 0;
    i_disp_alu_op_sel = '0; i_disp_pc = '0; i_disp_imm = '0; i_disp_pred_jmpaddr = '0;
    i_disp_rob_tag = '0; i_disp_rs1_rdy = 0; i_disp_rs2_rdy = 0; i_disp_rs1 = '0; i_disp_rs2 = '0;
    i_cdb0_vld = 0; i_cdb1_vld = 0; i_cdb0_tag = '0; i_cdb1_tag = '0;
    i_cdb0_data = '0; i_cdb1_data = '0;
  endtask

  task automatic disp(input logic [PC_W-1:0] pc, input logic [TAG_W-1:0] rob,
                      input logic r1_rdy, input logic [DATA_W-1:0] r1,
                      input logic r2_rdy, input logic [DATA_W-1:0] r2);
    i_disp_vld = 1; i_disp_pc = pc; i_disp_rob_tag = rob;
    i_disp_rs1_rdy = r1_rdy; i_disp_rs1 = r1; i_disp_rs2_rdy = r2_rdy; i_disp_rs2 = r2;
  endtask

  task automatic cdb0(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    i_cdb0_vld = 1; i_cdb0_tag = tag; i_cdb0_data = data;
  endtask

  task automatic cdb1(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    i_cdb1_vld = 1; i_cdb1_tag = tag; i_cdb1_data = data;
  endtask

  initial begin
    idle();
    rst = 1; i_ex_accessable = 1;
    settle();
    check("rst_is_vld", 64'(o_is_vld), 64'd0);
    check("rst_full", 64'(o_full), 64'd0);
    tick(); tick();
    check("rst_held_is_vld", 64'(o_is_vld), 64'd0);
    rst = 0;
    settle();
    check("rst_o_rs1", 64'(o_rs1), 64'd0);
    check("rst_o_pc", 64'(o_pc), 64'd0);
    check("rst_o_rob_tag", 64'(o_rob_tag), 64'd0);
    check("rst_full_after", 64'(o_full), 64'd0);

    // BEQ with both operands ready issues the cycle after dispatch
    disp(32'h100, 6'd1, 1, 32'd5, 1, 32'd5);
    settle();
    check("beq_no_issue_empty", 64'(o_is_vld), 64'd0);
    tick(); idle(); settle();
    check("beq_is_vld", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("beq_is_vld_drop", 64'(o_is_vld), 64'd0);
    check("beq_rs1", 64'(o_rs1), 64'd5);
    check("beq_rs2", 64'(o_rs2), 64'd5);
    check("beq_pc", 64'(o_pc), 64'h100);
    check("beq_rob", 64'(o_rob_tag), 64'd1);

    // rs1 waits on tag 3, delivered on cdb1 two cycles later
    disp(32'h200, 6'd2, 0, 32'd3, 1, 32'd7);
    tick(); idle(); settle();
    check("wake_wait0", 64'(o_is_vld), 64'd0);
    tick(); cdb1(6'd3, 32'h1234); settle();
    check("wake_no_fwd", 64'(o_is_vld), 64'd0);
    tick(); idle(); settle();
    check("wake_is_vld", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("wake_rs1", 64'(o_rs1), 64'h1234);
    check("wake_rs2", 64'(o_rs2), 64'd7);
    check("wake_pc", 64'(o_pc), 64'h200);

    // Dispatch-cycle bypass from cdb0, a JALR carrying an immediate
    disp(32'h300, 6'd3, 1, 32'd1, 0, 32'd7);
    i_disp_is_jalr = 1; i_disp_imm = 32'h10; i_disp_alu_op_sel = 4'h5;
    cdb0(6'd7, 32'd9);
    tick(); idle(); settle();
    check("byp_is_vld", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("byp_rs2", 64'(o_rs2), 64'd9);
    check("byp_jalr", 64'(o_is_jalr), 64'd1);
    check("byp_imm", 64'(o_imm), 64'h10);
    check("byp_op", 64'(o_alu_op_sel), 64'h5);

    // Both CDB ports match: cdb0 wins
    disp(32'h310, 6'd4, 1, 32'd1, 0, 32'd7);
    cdb0(6'd7, 32'h55); cdb1(6'd7, 32'h66);
    tick(); idle(); settle();
    check("byp2_is_vld", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("byp2_rs2_cdb0", 64'(o_rs2), 64'h55);
    check("byp2_jalr_clr", 64'(o_is_jalr), 64'd0);

    // In order: ready entry1 waits behind entry0 blocked on tag 2
    disp(32'h400, 6'd4, 0, 32'd2, 1, 32'd0);
    tick();
    disp(32'h404, 6'd5, 1, 32'h11, 1, 32'h22);
    settle();
    check("ord_blk0", 64'(o_is_vld), 64'd0);
    tick(); idle(); settle();
    check("ord_blk1", 64'(o_is_vld), 64'd0);
    tick(); cdb0(6'd2, 32'hAA); settle();
    check("ord_blk2", 64'(o_is_vld), 64'd0);
    tick(); idle(); settle();
    check("ord_iss0", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("ord_iss1", 64'(o_is_vld), 64'd1);
    check("ord_pc0", 64'(o_pc), 64'h400);
    check("ord_rs1_0", 64'(o_rs1), 64'hAA);
    tick(); settle();
    check("ord_done", 64'(o_is_vld), 64'd0);
    check("ord_pc1", 64'(o_pc), 64'h404);
    check("ord_rob1", 64'(o_rob_tag), 64'd5);

    // Fill all four slots behind a blocked head; extra dispatches while full are dropped
    disp(32'h500, 6'd10, 0, 32'd9, 1, 32'd0);
    settle(); check("fill_full0", 64'(o_full), 64'd0);
    tick(); disp(32'h504, 6'd11, 1, 32'd1, 1, 32'd1);
    settle(); check("fill_full1", 64'(o_full), 64'd0);
    tick(); disp(32'h508, 6'd12, 1, 32'd2, 1, 32'd2);
    tick(); disp(32'h50C, 6'd13, 1, 32'd3, 1, 32'd3);
    settle(); check("fill_full3", 64'(o_full), 64'd0);
    tick(); disp(32'h5F0, 6'd14, 1, 32'd4, 1, 32'd4);
    settle();
    check("fill_full4", 64'(o_full), 64'd1);
    check("fill_blocked", 64'(o_is_vld), 64'd0);
    tick(); idle(); cdb0(6'd9, 32'h99); settle();
    check("fill_still_full", 64'(o_full), 64'd1);
    tick(); idle(); disp(32'h5F4, 6'd15, 1, 32'd5, 1, 32'd5); settle();
    check("full_iss0", 64'(o_is_vld), 64'd1);
    check("full_iss_full", 64'(o_full), 64'd1);
    tick(); idle(); settle();
    check("full_iss1", 64'(o_is_vld), 64'd1);
    check("full_pc0", 64'(o_pc), 64'h500);
    check("full_rs1_0", 64'(o_rs1), 64'h99);
    check("full_after_iss", 64'(o_full), 64'd0);
    tick(); settle();
    check("full_iss2", 64'(o_is_vld), 64'd1);
    check("full_pc1", 64'(o_pc), 64'h504);
    tick(); settle();
    check("full_iss3", 64'(o_is_vld), 64'd1);
    check("full_pc2", 64'(o_pc), 64'h508);
    tick(); settle();
    check("full_empty", 64'(o_is_vld), 64'd0);
    check("full_pc3", 64'(o_pc), 64'h50C);
    check("full_rob3", 64'(o_rob_tag), 64'd13);
    tick(); settle();
    check("full_drop_never", 64'(o_is_vld), 64'd0);

    // Flush with three pending, a ready head and a same-cycle dispatch
    i_ex_accessable = 0;
    disp(32'h600, 6'd20, 1, 32'd1, 1, 32'd1);
    tick(); disp(32'h604, 6'd21, 1, 32'd1, 1, 32'd1);
    tick(); disp(32'h608, 6'd22, 1, 32'd1, 1, 32'd1);
    tick(); disp(32'h6F0, 6'd23, 1, 32'd1, 1, 32'd1);
    i_ex_accessable = 1; i_flush = 1;
    settle();
    check("flush_mask", 64'(o_is_vld), 64'd0);
    tick(); idle(); settle();
    check("flush_empty", 64'(o_is_vld), 64'd0);
    check("flush_full", 64'(o_full), 64'd0);
    check("flush_pc_kept", 64'(o_pc), 64'h50C);
    tick(); settle();
    check("flush_no_ghost", 64'(o_is_vld), 64'd0);
    disp(32'h700, 6'd30, 1, 32'h77, 1, 32'h78);
    tick(); idle(); settle();
    check("post_flush_is_vld", 64'(o_is_vld), 64'd1);
    tick(); settle();
    check("post_flush_pc", 64'(o_pc), 64'h700);
    check("post_flush_idle", 64'(o_is_vld), 64'd0);

    // Mid-run reset with a pending entry also zeros the payload
    disp(32'h800, 6'd31, 0, 32'd40, 1, 32'd0);
    tick(); idle(); rst = 1; settle();
    check("mrst_is_vld", 64'(o_is_vld), 64'd0);
    tick(); rst = 0; cdb0(6'd40, 32'h4); settle();
    check("mrst_pc_zero", 64'(o_pc), 64'd0);
    check("mrst_rs1_zero", 64'(o_rs1), 64'd0);
    tick(); idle(); settle();
    check("mrst_no_issue", 64'(o_is_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
